// File: rtl/div_pkg.sv
// Shared widths and FSM encoding for the sequential signed divider.
package div_pkg;
  localparam int DVD_W = 10;
  localparam int DVS_W = 5;
  localparam int ITER  = 10;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;
endpackage

// File: rtl/fa.sv
// One-bit full adder cell shared with the multiplier array.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/trial_sub.sv
// Ripple subtractor a - b built from fa cells; borrow=1 means a < b.
module trial_sub
  import div_pkg::*;
(
  input  logic [DVS_W:0] a,
  input  logic [DVS_W:0] b,
  output logic [DVS_W:0] diff,
  output logic           borrow
);
  logic [DVS_W+1:0] c;

  assign c[0] = 1'b1;

  for (genvar i = 0; i < DVS_W + 1; i++) begin : g_bit
    fa u_fa (
      .a  (a[i]),
      .b  (~b[i]),
      .ci (c[i]),
      .s  (diff[i]),
      .co (c[i+1])
    );
  end

  assign borrow = ~c[DVS_W+1];
endmodule

// File: rtl/signed_div.sv
// Radix-2 restoring signed divider: 10-bit dividend / 5-bit divisor, one quotient bit per cycle.
module signed_div
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DVD_W-1:0] D1,
  input  logic [DVS_W-1:0] D2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DVD_W-1:0] quot,
  output logic [DVS_W-1:0] rem,
  output logic             dz,
  output logic             ovf
);
  state_t           state, state_nxt;
  logic [DVD_W-1:0] dq;
  logic [DVS_W-1:0] dvs;
  logic [DVS_W:0]   p;
  logic [DVS_W:0]   shifted;
  logic [DVS_W:0]   diff;
  logic             borrow;
  logic [3:0]       cnt;
  logic             neg_q, neg_r, ovf_cand;

  assign in_ready = (state == IDLE);
  assign shifted  = {p[DVS_W-1:0], dq[DVD_W-1]};

  trial_sub u_sub (
    .a      (shifted),
    .b      ({1'b0, dvs}),
    .diff   (diff),
    .borrow (borrow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = (D2 == '0) ? DONE : CALC;
      CALC: if (cnt == 4'(ITER - 1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq        <= '0;
      dvs       <= '0;
      p         <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      ovf_cand  <= 1'b0;
      quot      <= '0;
      rem       <= '0;
      dz        <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            neg_q    <= D1[DVD_W-1] ^ D2[DVS_W-1];
            neg_r    <= D1[DVD_W-1];
            dq       <= D1[DVD_W-1] ? -D1 : D1;
            dvs      <= D2[DVS_W-1] ? -D2 : D2;
            p        <= '0;
            cnt      <= '0;
            ovf_cand <= (D1 == 10'h200) && (D2 == '1);
            if (D2 == '0) begin
              quot <= '0;
              rem  <= '0;
              dz   <= 1'b1;
            end
          end
        end
        CALC: begin
          p   <= borrow ? shifted : diff;
          dq  <= {dq[DVD_W-2:0], ~borrow};
          cnt <= cnt + 4'd1;
        end
        FIX: begin
          // |quotient| of 512 wraps to -512 either way, which is the ovf result
          quot <= neg_q ? -dq : dq;
          rem  <= DVS_W'(neg_r ? -p : p);
          ovf  <= ovf_cand;
        end
        DONE: begin
          // out_valid trails DONE entry by one cycle, so a handshake needs it already high
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            dz        <= 1'b0;
            ovf       <= 1'b0;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_signed_div.sv
// Directed-vector bench for signed_div: results, flags, latency, backpressure, mid-op reset.
module tb_signed_div;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] D1;
  logic [4:0] D2;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] quot;
  logic [4:0] rem;
  logic       dz;
  logic       ovf;

  int n_vec = 0;
  int n_err = 0;

  signed_div dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .D1        (D1),
    .D2        (D2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .rem       (rem),
    .dz        (dz),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " in_ready"},  32'(in_ready),  1);
    chk({tag, " out_valid"}, 32'(out_valid), 0);
    chk({tag, " quot"},      $signed(quot),  0);
    chk({tag, " rem"},       $signed(rem),   0);
    chk({tag, " dz"},        32'(dz),        0);
    chk({tag, " ovf"},       32'(ovf),       0);
  endtask

  // Issue one op, wait (bounded) for out_valid, check results, then complete the handshake.
  task automatic run_op(input string tag, input int d1, input int d2,
                        input int eq, input int er, input int edz,
                        input int eovf, input int elat);
    int lat;
    @(negedge clk);
    chk({tag, " in_ready"}, 32'(in_ready), 1);
    D1 = 10'(d1);
    D2 = 5'(d2);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, lat, elat);
    chk({tag, " quot"}, $signed(quot), eq);
    chk({tag, " rem"},  $signed(rem),  er);
    chk({tag, " dz"},   32'(dz),   edz);
    chk({tag, " ovf"},  32'(ovf),  eovf);
    chk({tag, " busy"}, 32'(in_ready), 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " released"}, 32'(out_valid), 0);
    chk({tag, " idle"},     32'(in_ready),  1);
    chk({tag, " dz clr"},   32'(dz),        0);
    chk({tag, " ovf clr"},  32'(ovf),       0);
  endtask

  initial begin
    int lat;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    D1        = '0;
    D2        = '0;
    #12;
    chk_reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;

    run_op("100/7",   100,   7,   14,  2, 0, 0, 12);
    run_op("-100/7",  -100,  7,  -14, -2, 0, 0, 12);
    run_op("100/-7",  100,  -7,  -14,  2, 0, 0, 12);
    run_op("-100/-7", -100, -7,   14, -2, 0, 0, 12);
    run_op("-512/-1", -512, -1, -512,  0, 0, 1, 12);
    run_op("-512/1",  -512,  1, -512,  0, 0, 0, 12);
    run_op("511/-16", 511,  -16, -31, 15, 0, 0, 12);
    run_op("-5/-16",  -5,   -16,   0, -5, 0, 0, 12);
    run_op("3/5",     3,     5,    0,  3, 0, 0, 12);
    run_op("37/0",    37,    0,    0,  0, 1, 0, 1);

    // Backpressure: hold the result while a competing request is presented.
    @(negedge clk);
    D1 = 10'd200;
    D2 = 5'd9;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp latency", lat, 12);
    D1 = 10'd7;
    D2 = 5'd3;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("bp out_valid", 32'(out_valid), 1);
      chk("bp in_ready",  32'(in_ready),  0);
      chk("bp quot",      $signed(quot),  22);
      chk("bp rem",       $signed(rem),   2);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp release out_valid", 32'(out_valid), 0);
    chk("bp release in_ready",  32'(in_ready),  1);
    run_op("after bp 50/7", 50, 7, 7, 1, 0, 0, 12);

    // Reset during CALC discards the operation.
    @(negedge clk);
    D1 = 10'd300;
    D2 = 5'd11;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid-reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post-reset 100/7", 100, 7, 14, 2, 0, 0, 12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
